// File: rtl/ovi_vector_responder_pkg.sv
// Shared OVI bus types, widths and responder FSM states for the vector-side responder.
package ovi_vector_responder_pkg;

    localparam int OVI_INSTR_WIDTH = 32;
    localparam int OVI_OPND_WIDTH  = 64;
    localparam int OVI_VL_WIDTH    = 8;
    localparam int OVI_SEW_WIDTH   = 3;
    localparam int OVI_SEW_MAX     = 3;

    typedef struct packed {
        logic [OVI_INSTR_WIDTH-1:0] instr;
        logic [OVI_OPND_WIDTH-1:0]  opnd;
        logic [OVI_VL_WIDTH-1:0]    vl;
        logic [OVI_SEW_WIDTH-1:0]   sew;
        logic                       valid;
    } core_issue_bus;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest_reg;
        logic       illegal;
    } core_completed_bus;

    typedef enum logic [1:0] {RSP_IDLE, RSP_EXEC, RSP_COMPLETE} rsp_state_t;

    // One queued instruction: only what the responder needs to time and retire it.
    typedef struct packed {
        logic [OVI_INSTR_WIDTH-1:0] instr;
        logic [OVI_VL_WIDTH-1:0]    vl;
        logic [OVI_SEW_WIDTH-1:0]   sew;
    } issue_entry_t;

    localparam int ENTRY_W = $bits(issue_entry_t);

endpackage

// File: rtl/ovi_issue_fifo.sv
// Circular issue queue with registered occupancy count; push is dropped when full, pop when empty.
module ovi_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ovi_vector_responder.sv
// Vector-unit side of the OVI issue/complete handshake: queues issues, models execution
// time from vl/sew and returns one completion pulse per accepted instruction.
module ovi_vector_responder
    import ovi_vector_responder_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BASE_LAT   = 3,
    parameter int LANE_BYTES = 8,
    parameter int MAX_VL     = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  core_issue_bus     CORE_ISSUE,
    output logic              ISSUE_READY,
    output core_completed_bus CORE_COMPLETED,
    output logic              BUSY
);

    issue_entry_t              push_entry;
    issue_entry_t              head;
    logic [ENTRY_W-1:0]        head_bits;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      fifo_pop;

    rsp_state_t                state;
    logic [15:0]               counter;
    logic [4:0]                exec_dest;
    logic                      exec_illegal;
    logic                      head_illegal;
    logic [15:0]               head_lat;
    logic                      unused_issue_bits;

    function automatic logic [15:0] calc_lat(input logic [OVI_VL_WIDTH-1:0]  vl,
                                             input logic [OVI_SEW_WIDTH-1:0] sew);
        logic [15:0] bytes;
        bytes = 16'(vl) << sew;
        return 16'(BASE_LAT) + ((bytes + 16'(LANE_BYTES - 1)) / 16'(LANE_BYTES));
    endfunction

    assign push_entry = '{instr: CORE_ISSUE.instr, vl: CORE_ISSUE.vl, sew: CORE_ISSUE.sew};
    assign head       = issue_entry_t'(head_bits);

    ovi_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (CORE_ISSUE.valid),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ISSUE_READY  = !fifo_full;
    assign BUSY         = (fifo_count != '0) || (state != RSP_IDLE);
    assign fifo_pop     = !fifo_empty && (state == RSP_IDLE || state == RSP_COMPLETE);
    assign head_illegal = (int'(head.vl) > MAX_VL) || (int'(head.sew) > OVI_SEW_MAX);
    // Illegal instructions take a single cycle so they retire right after the pop.
    assign head_lat     = head_illegal ? 16'd1 : calc_lat(head.vl, head.sew);

    assign unused_issue_bits = ^{CORE_ISSUE.opnd, head.instr[31:12], head.instr[6:0]};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= RSP_IDLE;
            counter        <= '0;
            CORE_COMPLETED <= '0;
        end else begin
            CORE_COMPLETED <= '0;
            case (state)
                RSP_IDLE, RSP_COMPLETE: begin
                    if (fifo_pop) begin
                        exec_dest    <= head.instr[11:7];
                        exec_illegal <= head_illegal;
                        counter      <= head_lat - 16'd1;
                        state        <= RSP_EXEC;
                    end else begin
                        state <= RSP_IDLE;
                    end
                end
                RSP_EXEC: begin
                    if (counter == '0) begin
                        state                   <= RSP_COMPLETE;
                        CORE_COMPLETED.valid    <= 1'b1;
                        CORE_COMPLETED.dest_reg <= exec_dest;
                        CORE_COMPLETED.illegal  <= exec_illegal;
                    end else begin
                        counter <= counter - 16'd1;
                    end
                end
                default: state <= RSP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ovi_vector_responder.sv
// Self-checking bench: directed and random issues compared each cycle against a timing-level model.
module tb_ovi_vector_responder;
    import ovi_vector_responder_pkg::*;

    localparam int DEPTH      = 4;
    localparam int BASE_LAT   = 3;
    localparam int LANE_BYTES = 8;
    localparam int MAX_VL     = 64;

    logic              CLK = 1'b0;
    logic              RST_N;
    core_issue_bus     CORE_ISSUE;
    logic              ISSUE_READY;
    core_completed_bus CORE_COMPLETED;
    logic              BUSY;

    ovi_vector_responder #(
        .DEPTH      (DEPTH),
        .BASE_LAT   (BASE_LAT),
        .LANE_BYTES (LANE_BYTES),
        .MAX_VL     (MAX_VL)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .CORE_ISSUE     (CORE_ISSUE),
        .ISSUE_READY    (ISSUE_READY),
        .CORE_COMPLETED (CORE_COMPLETED),
        .BUSY           (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] dest;
        bit         illegal;
        int         lat;
    } job_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    job_t q[$];
    job_t cur;
    bit   active   = 0;
    int   done_at  = -10;
    bit   accepted;

    function automatic bit ref_illegal(input int vl, input int sew);
        return (vl > MAX_VL) || (sew > 3);
    endfunction

    function automatic int ref_lat(input int vl, input int sew);
        if (ref_illegal(vl, sew)) return 1;
        return BASE_LAT + (vl * (1 << sew) + LANE_BYTES - 1) / LANE_BYTES;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare every output.
    task automatic step(input bit rst, input bit v, input logic [31:0] instr,
                        input int vl, input int sew);
        bit   ready_before;
        bit   exp_valid;
        job_t j;
        RST_N            = !rst;
        CORE_ISSUE.valid = v;
        CORE_ISSUE.instr = instr;
        CORE_ISSUE.vl    = 8'(vl);
        CORE_ISSUE.sew   = 3'(sew);
        CORE_ISSUE.opnd  = {$urandom, $urandom};
        ready_before     = (q.size() < DEPTH);
        @(posedge CLK);
        cyc++;
        if (rst) begin
            q.delete();
            active   = 0;
            accepted = 0;
        end else begin
            accepted = v && ready_before;
            if (active && cyc == done_at + 1) active = 0;
            if (!active && q.size() > 0) begin
                cur     = q.pop_front();
                active  = 1;
                done_at = cyc + cur.lat;
            end
            if (accepted) begin
                j.dest    = instr[11:7];
                j.illegal = ref_illegal(vl, sew);
                j.lat     = ref_lat(vl, sew);
                q.push_back(j);
            end
        end
        exp_valid = active && (cyc == done_at);
        #1;
        chk("issue_ready", 32'(ISSUE_READY), 32'(q.size() < DEPTH));
        chk("busy", 32'(BUSY), 32'((q.size() != 0) || active));
        chk("cmp_valid", 32'(CORE_COMPLETED.valid), 32'(exp_valid));
        chk("cmp_dest", 32'(CORE_COMPLETED.dest_reg), exp_valid ? 32'(cur.dest) : 32'd0);
        chk("cmp_illegal", 32'(CORE_COMPLETED.illegal), exp_valid ? 32'(cur.illegal) : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'd0, 0, 0);
    endtask

    task automatic issue_hold(input logic [31:0] instr, input int vl, input int sew);
        int budget;
        budget = 200;
        do begin
            step(0, 1, instr, vl, sew);
            budget--;
        end while (!accepted && budget > 0);
        chk("issue_accept_timeout", 32'(accepted), 32'd1);
    endtask

    initial begin
        int acc_cyc;
        int seen_cyc;
        int pulses;
        logic [31:0] ins;

        CORE_ISSUE = '0;
        RST_N      = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1, 0, 32'd0, 0, 0);
        idle(2);

        // Single issue vl=8 sew=32b: lat 7, pulse 8 cycles after accept
        ins = 32'hABCD_0A80;
        step(0, 1, ins, 8, 2);
        acc_cyc  = cyc;
        seen_cyc = -1;
        pulses   = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 32'd0, 0, 0);
            if (CORE_COMPLETED.valid === 1'b1) begin
                pulses++;
                if (seen_cyc < 0) seen_cyc = cyc;
            end
        end
        chk("t1_latency", 32'(seen_cyc - acc_cyc), 32'd8);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_dest_field", 32'(ins[11:7]), 32'd21);

        // Back-to-back vl=0 issues, more than the queue holds
        for (int i = 0; i < 7; i++) issue_hold(32'(i) << 7 | 32'h57, 0, 0);
        idle(30);

        // Illegal vl, then legal vl=8 sew=64b, then sew=4, then sew=8b vl=64
        issue_hold(32'h0000_0380, 65, 0);
        issue_hold(32'h0000_0400, 8, 3);
        issue_hold(32'h0000_0480, 5, 4);
        issue_hold(32'h0000_0500, 64, 0);
        idle(40);

        // Sustained long-latency issue pressure: full queue while completions pop
        for (int i = 0; i < 8; i++) issue_hold($urandom, 8, 3);
        idle(110);

        // Reset in the middle of execution with work queued
        for (int i = 0; i < 4; i++) issue_hold(32'h0000_0F80 + 32'(i), 8, 3);
        idle(3);
        step(1, 0, 32'd0, 0, 0);
        idle(30);
        issue_hold(32'h0000_0B00, 16, 1);
        idle(15);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0), $urandom,
                 int'($urandom_range(0, 70)), int'($urandom_range(0, 4)));
        end
        idle(120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
